particle_cell_loader: RTL
=========================

Name: particle_cell_loader

Overview:
- Ingest stage directly upstream of the simulator's cell memories; consumes the 256-bit particle records streamed in at load time.
- Bins each record into a spatial cell from the top bits of its position fields and issues one write per record: cell id, slot address within the cell, record data.
- Tracks per-cell occupancy and reports overflow and completion, after which the simulator may start stepping.

Parameters:
- AXIS_BITS, 2, cell-coordinate bits per axis; NUM_CELLS = 2^(3*AXIS_BITS) = 64
- CELL_DEPTH, 16, maximum records stored per cell
- N_PARTICLES, 300, records expected per load; load completes after this many are accepted

Ports:
- fast_clk  in  1  clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear occupancy and begin a load
- data_in_ready  in  1  input record valid
- data_in  in  256  particle record; x=[31:0], y=[63:32], z=[95:64], unsigned fixed point
- in_accept  out  1  loader can take a record this cycle
- elem_write  out  1  write strobe to cell memory
- wr_cell  out  3*AXIS_BITS  target cell id {cz,cy,cx}
- wr_addr  out  clog2(CELL_DEPTH)  slot within cell
- wr_data  out  256  record being written
- load_done  out  1  high while in DONE
- overflow  out  1  sticky: at least one record dropped in this load
- accepted_count  out  clog2(N_PARTICLES+1)  records accepted this load

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; all outputs 0; occupancy counters 0; overflow 0; accepted_count 0.
- States:
  - IDLE: wait; start=1 -> LOAD.
  - LOAD: accept records; accepted_count reaching N_PARTICLES -> DONE.
  - DONE: hold results; start=1 -> LOAD.
- start in IDLE or DONE: same edge clears all occupancy counters, overflow and accepted_count. start while in LOAD is ignored.
- in_accept = (state==LOAD) && (accepted_count < N_PARTICLES), registered. A record transfers when data_in_ready && in_accept.
- Cell mapping: cx = x[31:32-AXIS_BITS]; likewise cy from y, cz from z; wr_cell = {cz,cy,cx}.
- Latency: a record transferred at edge t appears at edge t+1 with elem_write=1, wr_addr = that cell's occupancy before increment, wr_data = record. The counter increments at the same edge.
- Cell full (occupancy == CELL_DEPTH): no elem_write, record dropped, overflow set. The record still counts toward accepted_count.
- Back-to-back records to the same cell in consecutive cycles get consecutive slot addresses; the counter update forwards correctly, with no stall.
- The final transfer takes the state to DONE at the same edge it writes. load_done rises that cycle and in_accept drops.
- elem_write is 0 in every cycle without a written transfer. wr_cell, wr_addr and wr_data hold their last value.
- Reset asserted mid-load: everything returns to reset values immediately. No partial write strobe is issued after reset deassertion.
- Counters never wrap. Occupancy saturates at CELL_DEPTH; accepted_count stops at N_PARTICLES.

Optional Feature:
- Macro LOADER_DROP_CNT_EN.
- Defined: adds output port drop_count, width clog2(N_PARTICLES+1). It counts dropped records, clears on start and reset, and saturates.
- Undefined: port and counter absent; overflow flag only.

Test Plan:
- Reset then start, 300 records with x=y=z=0x0000_0000 -> 16 writes to cell 0 at addr 0..15. overflow=1 after the 17th record; 284 dropped; load_done after the 300th; accepted_count=300; drop_count=284 if enabled.
- Records with x=0x4000_0000, y=0xC000_0000, z=0x8000_0000 -> wr_cell = {2,3,1} = 6'b10_11_01; first addr 0, next addr 1.
- 64 records, one per cell, data_in_ready held high every cycle -> 64 elem_write pulses, each addr 0, each one cycle after its transfer; overflow=0.
- Drive reset=0 after 100 records, then release and pulse start -> outputs 0 during reset; new load starts at addr 0 for all cells; accepted_count restarts at 0.
- data_in_ready toggled 1,0,1,0 -> writes only one cycle after high cycles; alternating same-cell records get consecutive addresses.
- start pulsed while in LOAD -> ignored; counts and occupancy unchanged.

Source files
------------

// File: rtl/particle_cell_loader.sv
// particle_cell_loader
//   Load-time ingest stage in front of the cell memories. Each accepted
//   256-bit particle record is binned into a spatial cell taken from the top
//   AXIS_BITS of its x/y/z fields and written to the next free slot of that
//   cell one cycle after the transfer. Per-cell occupancy saturates at
//   CELL_DEPTH; records that find their cell full are dropped and raise the
//   sticky overflow flag. The load ends after N_PARTICLES accepted records.
//
//   Handshake: a record transfers on a rising edge where
//   data_in_ready && in_accept. in_accept is registered and only depends on
//   loader state, never on data_in_ready in the same cycle.
//
//   Optional build macro: LOADER_DROP_CNT_EN adds the drop_count output,
//   a saturating count of dropped records for the current load.
module particle_cell_loader #(
    parameter int AXIS_BITS   = 2,
    parameter int CELL_DEPTH  = 16,
    parameter int N_PARTICLES = 300
) (
    input  logic                               fast_clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               data_in_ready,
    input  logic [255:0]                       data_in,
    output logic                               in_accept,
    output logic                               elem_write,
    output logic [3*AXIS_BITS-1:0]             wr_cell,
    output logic [$clog2(CELL_DEPTH)-1:0]      wr_addr,
    output logic [255:0]                       wr_data,
    output logic                               load_done,
    output logic                               overflow,
    output logic [$clog2(N_PARTICLES+1)-1:0]   accepted_count,
`ifdef LOADER_DROP_CNT_EN
    output logic [$clog2(N_PARTICLES+1)-1:0]   drop_count,
`endif
    output logic [1:0]                         o_dbg_state
);

    localparam int CW        = 3 * AXIS_BITS;
    localparam int NUM_CELLS = 1 << CW;
    localparam int AW        = $clog2(CELL_DEPTH);
    localparam int OW        = $clog2(CELL_DEPTH + 1);
    localparam int NW        = $clog2(N_PARTICLES + 1);

    localparam logic [OW-1:0] OCC_FULL  = OW'(CELL_DEPTH);
    localparam logic [NW-1:0] CNT_LAST  = NW'(N_PARTICLES - 1);
    localparam logic [NW-1:0] CNT_MAX   = NW'(N_PARTICLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_in_accept;
    logic            r_elem_write;
    logic [CW-1:0]   r_wr_cell;
    logic [AW-1:0]   r_wr_addr;
    logic [255:0]    r_wr_data;
    logic            r_load_done;
    logic            r_overflow;
    logic [NW-1:0]   r_count;
    logic [OW-1:0]   r_occ [NUM_CELLS];

    logic            w_start_ok;
    logic [CW-1:0]   w_cell;
    logic [OW-1:0]   w_occ;
    logic            w_full;
    logic            w_xfer;
    logic            w_write;
    logic            w_last;

    // start only restarts a load from IDLE or DONE; a pulse during LOAD is ignored
    assign w_start_ok = start && (r_state != S_LOAD);

    // Cell id {cz,cy,cx} from the most significant bits of each position field
    assign w_cell = {data_in[95:96-AXIS_BITS],
                     data_in[63:64-AXIS_BITS],
                     data_in[31:32-AXIS_BITS]};

    // Occupancy is updated on the transfer edge itself, so a record to the
    // same cell on the very next cycle already sees the incremented value.
    assign w_occ   = r_occ[w_cell];
    assign w_full  = (w_occ == OCC_FULL);
    assign w_xfer  = data_in_ready && r_in_accept;
    assign w_write = w_xfer && !w_full;
    assign w_last  = (r_count == CNT_LAST);

    // Load control FSM with registered handshake, write port and status outputs
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_in_accept  <= 1'b0;
            r_elem_write <= 1'b0;
            r_wr_cell    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
            r_count      <= '0;
        end else begin
            r_elem_write <= 1'b0;
            if (w_start_ok) begin
                r_state     <= S_LOAD;
                r_in_accept <= 1'b1;
                r_load_done <= 1'b0;
                r_overflow  <= 1'b0;
                r_count     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_in_accept <= 1'b0;
                    end
                    S_LOAD: begin
                        if (w_xfer) begin
                            r_count <= r_count + NW'(1);
                            if (w_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_elem_write <= 1'b1;
                                r_wr_cell    <= w_cell;
                                r_wr_addr    <= w_occ[AW-1:0];
                                r_wr_data    <= data_in;
                            end
                            if (w_last) begin
                                r_state     <= S_DONE;
                                r_in_accept <= 1'b0;
                                r_load_done <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_in_accept <= 1'b0;
                        r_load_done <= 1'b1;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_in_accept <= 1'b0;
                        r_load_done <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Per-cell occupancy counters: cleared on start, bumped on each stored record
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_occ[i] <= '0;
            end
        end else if (w_start_ok) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                r_occ[i] <= '0;
            end
        end else if (w_write) begin
            r_occ[w_cell] <= w_occ + OW'(1);
        end
    end

`ifdef LOADER_DROP_CNT_EN
    logic [NW-1:0] r_drop;

    // Saturating count of records dropped because their cell was full
    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
        end else if (w_start_ok) begin
            r_drop <= '0;
        end else if (w_xfer && w_full && (r_drop != CNT_MAX)) begin
            r_drop <= r_drop + NW'(1);
        end
    end

    assign drop_count = r_drop;
`endif

    assign in_accept      = r_in_accept;
    assign elem_write     = r_elem_write;
    assign wr_cell        = r_wr_cell;
    assign wr_addr        = r_wr_addr;
    assign wr_data        = r_wr_data;
    assign load_done      = r_load_done;
    assign overflow       = r_overflow;
    assign accepted_count = r_count;
    assign o_dbg_state    = r_state;

endmodule
